// File: rtl/cpu6_ifu_pkg.sv
// ============================================================================
// Module      : cpu6_ifu_pkg
// Description : Shared widths, reset PC and fetch-buffer entry type for the
//               cpu6 instruction fetch unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu6_ifu_pkg;

    localparam int          CPU6_XLEN        = 32;
    localparam logic [31:0] CPU6_RESET_PC    = 32'h0000_0000;
    localparam int          CPU6_OPCODE_SIZE = 7;
    localparam int          CPU6_FUNCT3_SIZE = 3;
    localparam int          CPU6_FUNCT7_SIZE = 7;

    typedef struct packed {
        logic [CPU6_XLEN-1:0] pc;
        logic [CPU6_XLEN-1:0] word;
    } fetch_entry_t;

endpackage : cpu6_ifu_pkg

`default_nettype wire

// File: rtl/cpu6_ifu_fifo.sv
// ============================================================================
// Module      : cpu6_ifu_fifo
// Description : Synchronous in-order FIFO with flush; head reads zero when empty.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu6_ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush && push) r_mem[r_wr_ptr] <= push_data;
    end

    // Upstream credit accounting must never let a push land on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !flush && r_count == CNT_W'(DEPTH)));

    assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule : cpu6_ifu_fifo

`default_nettype wire

// File: rtl/cpu6_ifu.sv
// ============================================================================
// Module      : cpu6_ifu
// Description : cpu6 instruction fetch unit: PC, credit-limited fetch issue,
//               response buffering and redirect flush.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu6_ifu
    import cpu6_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU6_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic                        imem_req,
    output logic [31:0]                 imem_addr,
    input  logic                        imem_ack,
    input  logic                        imem_rvalid,
    input  logic [31:0]                 imem_rdata,
    input  logic                        redirect,
    input  logic [31:0]                 redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [31:0]                 instr,
    output logic [31:0]                 instr_pc,
    output logic [CPU6_OPCODE_SIZE-1:0] op,
    output logic [CPU6_FUNCT3_SIZE-1:0] funct3,
    output logic [CPU6_FUNCT7_SIZE-1:0] funct7
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic          w_deq;
    logic          w_acc;
    logic          w_push;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    assign w_deq      = instr_valid & instr_ready;
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req   = resetn & ~redirect &
                        ((w_inflight - (CW+1)'(w_deq)) < (CW+1)'(DEPTH));
    assign imem_addr  = r_pc;
    assign w_acc      = imem_req & imem_ack;

    // When nothing is pending a drop, the oldest in-flight request was issued
    // exactly r_outstanding words behind the next fetch address.
    assign w_push            = imem_rvalid & ~redirect & (r_drop == '0);
    assign w_push_entry.pc   = r_pc - (32'(r_outstanding) << 2);
    assign w_push_entry.word = imem_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect) begin
            r_pc          <= redirect_pc & ~32'd3;
            // Every request still in flight is stale now, including those
            // already counted in r_drop, so the drop count is reloaded.
            r_drop        <= r_outstanding - CW'(imem_rvalid);
            r_outstanding <= r_outstanding - CW'(imem_rvalid);
        end else begin
            if (w_acc) r_pc <= r_pc + 32'd4;
            r_outstanding <= r_outstanding + CW'(w_acc) - CW'(imem_rvalid);
            if (imem_rvalid && r_drop != '0) r_drop <= r_drop - CW'(1);
        end
    end

    cpu6_ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_deq),
        .head      (w_head),
        .count     (w_count)
    );

    assign instr_valid = (w_count != '0) & ~redirect;
    assign instr       = w_head.word;
    assign instr_pc    = w_head.pc;
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];

endmodule : cpu6_ifu

`default_nettype wire

// File: tb/tb_cpu6_ifu.sv
// ============================================================================
// Module      : tb_cpu6_ifu
// Description : Directed self-checking bench for cpu6_ifu with an in-order
//               latency-programmable instruction memory model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu6_ifu;
    import cpu6_ifu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [CPU6_OPCODE_SIZE-1:0] op;
    logic [CPU6_FUNCT3_SIZE-1:0] funct3;
    logic [CPU6_FUNCT7_SIZE-1:0] funct7;

    int   errors = 0;
    int   checks = 0;
    int   lat    = 1;
    int   cyc    = 0;
    logic ack_en = 1'b1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rq_t;
    rq_t         mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_w[$];

    always #5 clk = ~clk;
    assign imem_ack = ack_en;

    cpu6_ifu #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A_5A5A, 2'b11};
    endfunction

    // Memory model: in-order responses, lat cycles after acceptance.
    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_ack) mq.push_back('{imem_addr, cyc + lat});
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word_of(mq[0].addr);
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= '0;
            end
        end
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (resetn && instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            got_w.push_back(instr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] w;
        logic [31:0] exp_pc [12];
        exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114,
                   32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h2000, 32'h2004};

        resetn = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        step(); #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        step(); #1;
        chk("rst_addr", imem_addr, RPC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_funct3", 32'(funct3), 32'd0);
        chk("rst_funct7", 32'(funct7), 32'd0);

        // Reset release, L=1, sustained stream
        step(); resetn = 1'b1; #1;
        chk("c0_req", {31'b0, imem_req}, 32'd1);
        chk("c0_addr", imem_addr, 32'h100);
        step(); #1;
        chk("c1_addr", imem_addr, 32'h104);
        chk("c1_valid", {31'b0, instr_valid}, 32'd0);
        step(); #1;
        w = word_of(32'h100);
        chk("c2_addr", imem_addr, 32'h108);
        chk("c2_valid", {31'b0, instr_valid}, 32'd1);
        chk("c2_pc", instr_pc, 32'h100);
        chk("c2_instr", instr, w);
        chk("c2_op", 32'(op), {25'b0, w[6:0]});
        chk("c2_funct3", 32'(funct3), {29'b0, w[14:12]});
        chk("c2_funct7", 32'(funct7), {25'b0, w[31:25]});

        // Decode stall for 10 cycles
        step(); instr_ready = 1'b0; #1;
        chk("stall_req0", {31'b0, imem_req}, 32'd0);
        chk("stall_pc0", instr_pc, 32'h104);
        repeat (9) step();
        #1;
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_pc", instr_pc, 32'h104);
        chk("stall_instr", instr, word_of(32'h104));
        chk("stall_addr", imem_addr, 32'h10C);
        step(); instr_ready = 1'b1; #1;
        chk("resume_req", {31'b0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h10C);
        chk("resume_pc", instr_pc, 32'h104);
        step(); #1;
        chk("resume_pc1", instr_pc, 32'h108);
        chk("resume_addr1", imem_addr, 32'h110);
        step(); #1;
        chk("resume_pc2", instr_pc, 32'h10C);

        // imem_ack low for 5 cycles
        step(); ack_en = 1'b0; #1;
        chk("nack_pc", instr_pc, 32'h110);
        chk("nack_addr0", imem_addr, 32'h118);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("nack_addr", imem_addr, 32'h118);
            chk("nack_req", {31'b0, imem_req}, 32'd1);
        end
        step(); ack_en = 1'b1; #1;
        chk("ack_addr", imem_addr, 32'h118);
        chk("ack_valid", {31'b0, instr_valid}, 32'd0);
        step(); #1;
        chk("ack_addr1", imem_addr, 32'h11C);

        // Redirect coinciding with a response and instr_ready, misaligned target
        step(); redirect = 1'b1; redirect_pc = 32'h3002; #1;
        chk("rdr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdr_req", {31'b0, imem_req}, 32'd0);
        step(); redirect = 1'b0; #1;
        chk("rdr1_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdr1_addr", imem_addr, 32'h3000);
        chk("rdr1_req", {31'b0, imem_req}, 32'd1);
        step(); #1;
        chk("rdr2_valid", {31'b0, instr_valid}, 32'd0);
        step(); #1;
        chk("rdr3_pc", instr_pc, 32'h3000);
        step(); #1;
        chk("rdr4_pc", instr_pc, 32'h3004);

        // Build up two outstanding requests, then reset mid-stream
        step(); lat = 3; #1;
        chk("lat_pc", instr_pc, 32'h3008);
        step(); #1;
        chk("lat_pc1", instr_pc, 32'h300C);
        step(); resetn = 1'b0; #1;
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        step(); #1;
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_addr", imem_addr, RPC);
        chk("mrst_pc", instr_pc, 32'd0);

        // L=3 restart, redirect with two outstanding
        step(); resetn = 1'b1; #1;
        chk("r0_addr", imem_addr, RPC);
        chk("r0_req", {31'b0, imem_req}, 32'd1);
        step(); #1;
        chk("r1_addr", imem_addr, 32'h104);
        step(); #1;
        chk("r2_req", {31'b0, imem_req}, 32'd0);
        step(); redirect = 1'b1; redirect_pc = 32'h2000; #1;
        chk("n_valid", {31'b0, instr_valid}, 32'd0);
        step(); redirect = 1'b0; #1;
        chk("n1_req", {31'b0, imem_req}, 32'd1);
        chk("n1_addr", imem_addr, 32'h2000);
        step(); step(); step(); #1;
        chk("n4_valid", {31'b0, instr_valid}, 32'd0);
        step(); #1;
        chk("n5_valid", {31'b0, instr_valid}, 32'd1);
        chk("n5_pc", instr_pc, 32'h2000);
        chk("n5_instr", instr, word_of(32'h2000));
        step(); #1;
        chk("n6_pc", instr_pc, 32'h2004);
        step(); #1;

        // Whole consumed stream: order, no duplicates, no stale words
        chk("stream_len", {31'b0, got_pc.size() >= 12}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (i < got_pc.size()) begin
                chk($sformatf("stream_pc%0d", i), got_pc[i], exp_pc[i]);
                chk($sformatf("stream_w%0d", i), got_w[i], word_of(exp_pc[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu6_ifu

`default_nettype wire
